// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the requester beat handshakes and the FIFO write port that the
// round-robin write arbiter sits between.
//
// Handshake rule, all requesters: a beat moves from requester i on a rising
// clk edge where req_valid[i] and req_ready[i] are both 1. Once req_valid[i]
// is raised it is expected to stay up with stable req_data/req_last until that
// edge. On the FIFO side a write happens on every edge where fifo_wr_en is 1.
// The arbiter never raises fifo_wr_en while fifo_full is 1.
//
// Signals
//   req_valid  [NUM_REQ]             per-requester beat valid
//   req_last   [NUM_REQ]             per-requester final beat of a burst
//   req_data   [NUM_REQ*DATA_WIDTH]  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  [NUM_REQ]             per-requester beat accept
//   fifo_full                        FIFO cannot take a write this cycle
//   fifo_wr_en                       FIFO write strobe
//   fifo_wdata [DATA_WIDTH]          FIFO write data
//
// Modports
//   master : the side that owns the requesters and the FIFO (environment)
//   slave  : the arbiter
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wdata;

    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wdata
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_wdata
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one FIFO write port between NUM_REQ requesters.
// A grant is locked for a whole burst (until a beat with last, or MAX_BURST
// beats). Beats are forwarded combinationally to the FIFO while fifo_full is 0.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   bus          fifo_wr_arbiter_if.slave: requester handshakes + FIFO write
//   grant_id     currently granted requester (meaningful while busy)
//   busy         a burst is in progress (registered, state == BURST)
//   burst_cnt    completed bursts, wraps at 0xFFFF
//   forced_rel   one-cycle pulse after a MAX_BURST forced release
//   state_dbg    FSM state for observation: 0 = IDLE, 1 = BURST
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BCW       = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_wr_arbiter_if.slave      bus,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy,
    output logic [15:0]           burst_cnt,
    output logic                  forced_rel,
    output logic                  state_dbg
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [15:0]     burst_cnt_q, burst_cnt_d;
    logic            forced_q, forced_d;

    // Per-requester data slices so the granted beat is a plain array select.
    logic [DATA_WIDTH-1:0] req_slice [NUM_REQ];
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign req_slice[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin pick: first valid requester after rr_ptr, wrapping.
    // Walking offsets from far to near lets the nearest one win without a break.
    logic           pick_valid;
    logic [IDW-1:0] pick_id;
    logic [IDW-1:0] idx;
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (bus.req_valid[idx]) begin
                pick_valid = 1'b1;
                pick_id    = idx;
            end
        end
    end

    logic in_burst, valid_g, last_g, xfer, at_limit;
    assign in_burst = (state_q == BURST);
    assign valid_g  = bus.req_valid[grant_q];
    assign last_g   = bus.req_last[grant_q];
    assign xfer     = in_burst & valid_g & ~bus.fifo_full;
    // The beat now transferring is beat number MAX_BURST of this grant.
    assign at_limit = (beat_cnt_q == BCW'(MAX_BURST - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= IDW'(NUM_REQ - 1);
            beat_cnt_q  <= '0;
            burst_cnt_q <= '0;
            forced_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            forced_q    <= forced_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        burst_cnt_d = burst_cnt_q;
        forced_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_id;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    if (last_g || at_limit) begin
                        rr_ptr_d    = grant_q;
                        beat_cnt_d  = '0;
                        burst_cnt_d = burst_cnt_q + 16'd1;
                        state_d     = IDLE;
                        // A limit hit that coincides with last is a normal end.
                        forced_d    = at_limit & ~last_g;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BCW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (in_burst && !bus.fifo_full) begin
            bus.req_ready[grant_q] = 1'b1;
        end
        bus.fifo_wr_en = xfer;
        bus.fifo_wdata = in_burst ? req_slice[grant_q] : '0;
    end

    assign grant_id   = grant_q;
    assign busy       = in_burst;
    assign burst_cnt  = burst_cnt_q;
    assign forced_rel = forced_q;
    assign state_dbg  = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int MB  = 16;
    localparam int IDW = 2;
    localparam int W   = IDW + DW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic [15:0]    burst_cnt;
    logic           forced_rel;
    logic           state_dbg;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .grant_id   (grant_id),
        .busy       (busy),
        .burst_cnt  (burst_cnt),
        .forced_rel (forced_rel),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- requester driver ----------------
    // src_q[i] holds {last, data} beats waiting at requester i.
    logic [DW:0]    src_q [NR][$];
    logic [NR-1:0]  fire_v;
    // Scoreboard: expected {id, data} per FIFO write, in order.
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   obs_q[$];
    int             obs_cyc_q[$];

    function automatic void drive_all();
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0) begin
                bus.req_valid[i]           = 1'b1;
                bus.req_last[i]            = src_q[i][0][DW];
                bus.req_data[i*DW +: DW]   = src_q[i][0][DW-1:0];
            end else begin
                bus.req_valid[i]           = 1'b0;
                bus.req_last[i]            = 1'b0;
                bus.req_data[i*DW +: DW]   = '0;
            end
        end
    endfunction

    always begin
        @(negedge clk);
        fire_v = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (fire_v[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        drive_all();
    end

    // FIFO-side monitor
    always @(negedge clk) begin
        if (bus.fifo_wr_en === 1'b1) begin
            obs_q.push_back({grant_id, bus.fifo_wdata});
            obs_cyc_q.push_back(cyc);
        end
    end

    task automatic push_src(input int r, input int nbeats, input logic [DW-1:0] base,
                            input bit with_last, input bit add_exp);
        for (int b = 0; b < nbeats; b++) begin
            src_q[r].push_back({(with_last && b == nbeats - 1), base + DW'(b)});
            if (add_exp) exp_q.push_back({IDW'(r), base + DW'(b)});
        end
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            @(negedge clk);
            #1;
            if (obs_q.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.fifo_full = 1'b0;
        for (int i = 0; i < NR; i++) src_q[i].delete();
        drive_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        obs_q.delete();
        obs_cyc_q.delete();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.fifo_full = 1'b0;
        for (int i = 0; i < NR; i++) src_q[i].delete();
        push_src(2, 2, 32'hEE00, 1'b1, 1'b0);
        drive_all();
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b expected 0", bus.fifo_wr_en); end
        n_cmp++; if (bus.req_ready !== 4'h0) begin n_bad++; $display("FAIL reset_ready: got %h expected 0", bus.req_ready); end
        n_cmp++; if (burst_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_burst_cnt: got %h expected 0", burst_cnt); end
        n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        n_cmp++; if (forced_rel !== 1'b0) begin n_bad++; $display("FAIL reset_forced: got %b expected 0", forced_rel); end
        n_cmp++; if (bus.fifo_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h expected 0", bus.fifo_wdata); end
        n_cmp++; if (state_dbg !== 1'b0) begin n_bad++; $display("FAIL reset_state: got %b expected 0", state_dbg); end
    endtask

    task automatic test_single();
        bit ok;
        int start;
        logic [W-1:0] got, want;
        int gcyc;
        do_reset();
        @(negedge clk);
        src_q[0].push_back({1'b0, 32'hA1}); exp_q.push_back({2'd0, 32'hA1});
        src_q[0].push_back({1'b0, 32'hA2}); exp_q.push_back({2'd0, 32'hA2});
        src_q[0].push_back({1'b1, 32'hA3}); exp_q.push_back({2'd0, 32'hA3});
        @(posedge clk);
        #2;
        start = cyc;
        wait_obs(3, 20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_timeout: got %0d writes expected 3", obs_q.size()); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_last: got %b expected 1", busy); end
        for (int i = 0; i < 3; i++) begin
            got  = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            gcyc = (obs_cyc_q.size() > 0) ? obs_cyc_q.pop_front() : -1;
            want = exp_q.pop_front();
            n_cmp++; if (got !== want) begin n_bad++; $display("FAIL single_data%0d: got %h expected %h", i, got, want); end
            n_cmp++; if (gcyc != start + 1 + i) begin n_bad++; $display("FAIL single_cycle%0d: got %0d expected %0d", i, gcyc, start + 1 + i); end
        end
        @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
        n_cmp++; if (burst_cnt !== 16'd1) begin n_bad++; $display("FAIL single_burst_cnt: got %0d expected 1", burst_cnt); end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL single_extra_writes: got %0d expected 0", obs_q.size()); end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [W-1:0] got, want;
        int c0, c1, prev_last;
        do_reset();
        @(negedge clk);
        for (int rnd = 0; rnd < 2; rnd++)
            for (int r = 0; r < NR; r++)
                push_src(r, 2, 32'h100 * (r + 1) + 32'h10 * rnd, 1'b1, 1'b1);
        wait_obs(16, 100, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rr_timeout: got %0d writes expected 16", obs_q.size()); end
        prev_last = -1;
        for (int bidx = 0; bidx < 8; bidx++) begin
            for (int b = 0; b < 2; b++) begin
                got  = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
                if (b == 0) c0 = (obs_cyc_q.size() > 0) ? obs_cyc_q.pop_front() : -1;
                else        c1 = (obs_cyc_q.size() > 0) ? obs_cyc_q.pop_front() : -1;
                want = exp_q.pop_front();
                n_cmp++; if (got !== want) begin n_bad++; $display("FAIL rr_beat_b%0d_%0d: got %h expected %h", bidx, b, got, want); end
            end
            n_cmp++; if (c1 != c0 + 1) begin n_bad++; $display("FAIL rr_contig_b%0d: got %0d expected %0d", bidx, c1, c0 + 1); end
            if (prev_last >= 0) begin
                n_cmp++; if (c0 != prev_last + 2) begin n_bad++; $display("FAIL rr_gap_b%0d: got %0d expected %0d", bidx, c0, prev_last + 2); end
            end
            prev_last = c1;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [W-1:0] got, want;
        do_reset();
        @(negedge clk);
        push_src(2, 4, 32'hC1, 1'b1, 1'b1);
        wait_obs(1, 20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_first_timeout: got %0d writes expected 1", obs_q.size()); end
        @(posedge clk);
        #1;
        bus.fifo_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (bus.req_ready[2] !== 1'b0) begin n_bad++; $display("FAIL bp_ready_s%0d: got %b expected 0", s, bus.req_ready[2]); end
            n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL bp_wr_en_s%0d: got %b expected 0", s, bus.fifo_wr_en); end
            n_cmp++; if (busy !== 1'b1 || grant_id !== 2'd2) begin n_bad++; $display("FAIL bp_hold_s%0d: got busy=%b id=%0d expected busy=1 id=2", s, busy, grant_id); end
        end
        @(posedge clk);
        #1;
        bus.fifo_full = 1'b0;
        wait_obs(4, 20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_timeout: got %0d writes expected 4", obs_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got  = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            want = exp_q.pop_front();
            n_cmp++; if (got !== want) begin n_bad++; $display("FAIL bp_data%0d: got %h expected %h", i, got, want); end
        end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL bp_dup_writes: got %0d expected 0", obs_q.size()); end
    endtask

    task automatic test_forced_release();
        logic [W-1:0] got, want;
        int fcnt, fcyc, gcyc, cyc16;
        logic fbusy;
        do_reset();
        @(negedge clk);
        push_src(1, 18, 32'h1000, 1'b0, 1'b0);
        push_src(3, 1, 32'h3000, 1'b1, 1'b0);
        for (int b = 0; b < 16; b++) exp_q.push_back({2'd1, 32'h1000 + 32'(b)});
        exp_q.push_back({2'd3, 32'h3000});
        for (int b = 16; b < 18; b++) exp_q.push_back({2'd1, 32'h1000 + 32'(b)});
        fcnt = 0; fcyc = -1; fbusy = 1'bx;
        for (int t = 0; t < 80 && obs_q.size() < 19; t++) begin
            @(negedge clk);
            #1;
            if (forced_rel === 1'b1) begin fcnt++; fcyc = cyc; fbusy = busy; end
        end
        n_cmp++; if (obs_q.size() != 19) begin n_bad++; $display("FAIL fr_write_count: got %0d expected 19", obs_q.size()); end
        n_cmp++; if (fcnt != 1) begin n_bad++; $display("FAIL fr_pulse_count: got %0d expected 1", fcnt); end
        n_cmp++; if (fbusy !== 1'b0) begin n_bad++; $display("FAIL fr_idle_at_pulse: got busy=%b expected 0", fbusy); end
        cyc16 = -1;
        for (int i = 0; i < 19; i++) begin
            got  = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            gcyc = (obs_cyc_q.size() > 0) ? obs_cyc_q.pop_front() : -1;
            if (i == 15) cyc16 = gcyc;
            want = exp_q.pop_front();
            n_cmp++; if (got !== want) begin n_bad++; $display("FAIL fr_beat%0d: got %h expected %h", i, got, want); end
        end
        n_cmp++; if (fcyc != cyc16 + 1) begin n_bad++; $display("FAIL fr_pulse_cycle: got %0d expected %0d", fcyc, cyc16 + 1); end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        logic [W-1:0] got, want;
        do_reset();
        @(negedge clk);
        push_src(2, 1, 32'h2200, 1'b1, 1'b1);
        wait_obs(1, 20, ok);
        @(negedge clk);
        got  = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
        void'(obs_cyc_q.pop_front());
        want = exp_q.pop_front();
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL rmb_pre_burst: got %h expected %h", got, want); end
        push_src(0, 5, 32'h5000, 1'b1, 1'b1);
        wait_obs(2, 20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmb_timeout: got %0d writes expected 2", obs_q.size()); end
        for (int i = 0; i < 2; i++) begin
            got  = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            want = exp_q.pop_front();
            n_cmp++; if (got !== want) begin n_bad++; $display("FAIL rmb_beat%0d: got %h expected %h", i, got, want); end
        end
        obs_cyc_q.delete();
        exp_q.delete();
        @(posedge clk);
        #2;
        n_cmp++; if (bus.fifo_wr_en !== 1'b1 || burst_cnt !== 16'd1) begin n_bad++; $display("FAIL rmb_pre_state: got wr_en=%b cnt=%0d expected wr_en=1 cnt=1", bus.fifo_wr_en, burst_cnt); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL rmb_wr_en: got %b expected 0", bus.fifo_wr_en); end
        n_cmp++; if (bus.req_ready !== 4'h0) begin n_bad++; $display("FAIL rmb_ready: got %h expected 0", bus.req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmb_busy: got %b expected 0", busy); end
        n_cmp++; if (burst_cnt !== 16'd0) begin n_bad++; $display("FAIL rmb_burst_cnt: got %0d expected 0", burst_cnt); end
        for (int i = 0; i < NR; i++) src_q[i].delete();
        drive_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_src(1, 1, 32'h1111, 1'b1, 1'b1);
        push_src(3, 1, 32'h3333, 1'b1, 1'b1);
        wait_obs(2, 20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmb_post_timeout: got %0d writes expected 2", obs_q.size()); end
        for (int i = 0; i < 2; i++) begin
            got  = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            want = exp_q.pop_front();
            n_cmp++; if (got !== want) begin n_bad++; $display("FAIL rmb_post%0d: got %h expected %h", i, got, want); end
        end
    endtask

    task automatic test_wrap_sparse();
        bit ok;
        logic [W-1:0] got, want;
        do_reset();
        @(negedge clk);
        force dut.burst_cnt_q = 16'hFFFF;
        @(negedge clk);
        #1;
        n_cmp++; if (burst_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_preload: got %h expected ffff", burst_cnt); end
        release dut.burst_cnt_q;
        push_src(1, 1, 32'hB1, 1'b1, 1'b1);
        wait_obs(1, 20, ok);
        @(negedge clk);
        #1;
        n_cmp++; if (burst_cnt !== 16'h0000) begin n_bad++; $display("FAIL wrap_cnt: got %h expected 0000", burst_cnt); end
        got  = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
        want = exp_q.pop_front();
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL wrap_beat: got %h expected %h", got, want); end
        // rr_ptr now 1; only requester 0 asks, so the search must wrap to 0.
        @(negedge clk);
        push_src(0, 1, 32'hB0, 1'b1, 1'b1);
        wait_obs(1, 20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL sparse_timeout: got %0d writes expected 1", obs_q.size()); end
        got  = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
        want = exp_q.pop_front();
        n_cmp++; if (got !== want) begin n_bad++; $display("FAIL sparse_grant: got %h expected %h", got, want); end
        @(negedge clk);
        #1;
        n_cmp++; if (burst_cnt !== 16'd1) begin n_bad++; $display("FAIL sparse_cnt: got %0d expected 1", burst_cnt); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        bus.fifo_full = 1'b0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_forced_release();
        test_reset_mid_burst();
        test_wrap_sparse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by %0t expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the FIFO_AXI input FIFO among NUM_REQ requesters. Each requester presents bursts of beats on a valid/ready handshake with a last flag. The arbiter locks its grant for a whole burst and forwards beats to the FIFO write interface, honouring fifo_full. It sits directly upstream of the FIFO_in interface and is the only agent driving the FIFO write port.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- DATA_WIDTH, 32: beat width
- MAX_BURST, 16: beat limit per grant; forces release if last never arrives (≥1)
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester beat valid
- req_last  input  NUM_REQ  per-requester final beat of burst
- req_data  input  NUM_REQ*DATA_WIDTH  packed beat data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  per-requester beat accept
- fifo_full  input  1  FIFO cannot accept a write this cycle
- fifo_wr_en  output  1  FIFO write strobe
- fifo_wdata  output  DATA_WIDTH  FIFO write data
- grant_id  output  $clog2(NUM_REQ)  currently granted requester (valid when busy)
- busy  output  1  a burst is in progress
- burst_cnt  output  16  completed bursts, wraps at 0xFFFF
- forced_rel  output  1  single-cycle pulse when MAX_BURST forces release

## Operation
- FSM states: IDLE, BURST.
- Reset: state=IDLE, rr_ptr=NUM_REQ-1, grant_id=0, beat_cnt=0, burst_cnt=0, forced_rel=0. All outputs low/zero.
- IDLE: if any req_valid bit is set, select the first set bit searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ. Register it into grant_id and go to BURST. No beat transfers in IDLE; req_ready=0.
- BURST: req_ready[grant_id] = ~fifo_full; all other req_ready bits are 0.
- fifo_wr_en = req_valid[grant_id] & ~fifo_full (combinational). fifo_wdata = granted slice of req_data. fifo_wdata is 0 when not in BURST.
- A beat transfers when fifo_wr_en=1; beat_cnt increments on each transfer.
- End of burst occurs when a transfer has req_last[grant_id]=1, or when the transfer is beat number MAX_BURST. On end of burst:
  - rr_ptr <= grant_id
  - beat_cnt <= 0
  - burst_cnt increments
  - state <= IDLE
- If the MAX_BURST limit is reached without last, forced_rel pulses high for the next cycle. If last and the limit coincide, it is a normal end and forced_rel stays 0.
- req_valid deasserting mid-burst does not release the grant. The arbiter waits indefinitely for the granted requester.
- fifo_full high stalls with state, grant and beat_cnt held.
- beat_cnt width: $clog2(MAX_BURST+1).
- Asynchronous reset mid-burst returns to the reset values immediately. Any partially transferred burst is abandoned; no further beats are written.

## Timing
- Arbitration: 1 cycle. Requests are sampled in IDLE at edge N; req_ready can assert in cycle N+1.
- Forwarding latency: 0 cycles. A beat on req_* appears on fifo_wr_en/fifo_wdata in the same cycle.
- Per-burst overhead: exactly 1 idle cycle between bursts. Minimum burst of 1 beat occupies 2 cycles total.
- Throughput within a burst: 1 beat/cycle while fifo_full=0.
- busy = (state==BURST), registered.
- grant_id changes only on the IDLE→BURST transition.

## Test plan
- Single requester: req 0 sends a 3-beat burst 0xA1, 0xA2, 0xA3 (last on the third), fifo_full=0.
  - Required: fifo_wr_en high for exactly 3 consecutive cycles starting 1 cycle after request, data in order.
  - burst_cnt=1, busy falls the cycle after the last beat.
- Round robin: all 4 requesters continuously valid with 2-beat bursts.
  - Required grant order: 0, 1, 2, 3, 0, 1.
  - No interleaving of beats within a burst.
  - 1 idle cycle between bursts.
- Backpressure: req 2 sends a 4-beat burst with fifo_full high on beats 2–3 for 3 cycles.
  - Required: req_ready[2]=0 and fifo_wr_en=0 during the stall.
  - Data is not duplicated or dropped; all 4 beats are written in order.
- Forced release: MAX_BURST=16, req 1 streams without last.
  - Required: exactly 16 writes, then forced_rel pulses once and the FSM returns to IDLE.
  - With req 3 also pending, the next grant is 3.
- Reset mid-burst: assert rst_n=0 after beat 2 of a 5-beat burst.
  - Required: fifo_wr_en, req_ready, busy and burst_cnt are 0 immediately, without waiting for a clock edge.
  - After release, the first grant goes to the lowest-index valid requester.
- Counter wrap and sparse grant:
  - Preload 0xFFFF bursts; the next completed burst sets burst_cnt=0.
  - rr_ptr=1 with only req 0 valid grants 0 (wrap-around search).
